// File: rtl/digit_serial_adder_sub.sv
// Digit-serial add/subtract unit: a WIDTH-bit operation is processed DIGIT bits per
// clock through one ripple slice with a registered carry, taking NDIG = WIDTH/DIGIT cycles.
module digit_serial_adder_sub #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             ovf
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;

  logic [DIGIT:0]   slice;
  logic [WIDTH-1:0] dig_ext;
  logic [WIDTH-1:0] res_next;
  logic             msb_cin;
  logic             last;

  // One DIGIT-bit ripple slice; the result digit enters at the MSB end so that after
  // NDIG shifts the first (least significant) digit has reached bit 0.
  always_comb begin
    slice    = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
    dig_ext  = '0;
    dig_ext[DIGIT-1:0] = slice[DIGIT-1:0];
    res_next = (res_sh >> DIGIT) | (dig_ext << (WIDTH - DIGIT));
    msb_cin  = a_sh[DIGIT-1] ^ b_sh[DIGIT-1] ^ slice[DIGIT-1];
    last     = (cnt == CW'(NDIG - 1));
  end

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // in_ready/out_valid are registers and never depend combinationally on the inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      carry     <= 1'b0;
      a_sh      <= '0;
      b_sh      <= '0;
      res_sh    <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      S         <= '0;
      Cout      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            a_sh     <= A;
            b_sh     <= B ^ {WIDTH{sub}};
            carry    <= sub ? 1'b1 : Cin;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> DIGIT;
          b_sh   <= b_sh >> DIGIT;
          res_sh <= res_next;
          carry  <= slice[DIGIT];
          cnt    <= cnt + CW'(1);
          if (last) begin
            S         <= res_next;
            Cout      <= slice[DIGIT];
            ovf       <= msb_cin ^ slice[DIGIT];
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          // Returning to IDLE costs one cycle, so no accept coincides with the handoff.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_digit_serial_adder_sub.sv
// Bench for digit_serial_adder_sub: directed cases on a 16/4 instance plus randomized
// traffic on four width/digit configurations checked against an arithmetic model.
module tb_digit_serial_adder_sub;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: {ovf, Cout, S} from plain integer arithmetic on w-bit operands.
  function automatic logic [17:0] model(input int w, input logic [15:0] a, input logic [15:0] b,
                                        input logic cin, input logic sub);
    longint m, ua, ub, sa, sb, ur, sr;
    logic co, ov;
    logic [15:0] s;
    m  = longint'(1) << w;
    ua = longint'(a);
    ub = longint'(b);
    sa = (((ua >> (w - 1)) & 1) != 0) ? ua - m : ua;
    sb = (((ub >> (w - 1)) & 1) != 0) ? ub - m : ub;
    if (sub) begin
      ur = ua - ub + m;
      co = (ua >= ub);
      sr = sa - sb;
    end else begin
      ur = ua + ub + longint'(cin);
      co = (ur >= m);
      sr = sa + sb + longint'(cin);
    end
    s  = 16'(ur % m);
    ov = (sr < -(m / 2)) || (sr > (m / 2) - 1);
    return {ov, co, s};
  endfunction

  // ---------------- directed instance (16,4) ----------------
  logic        m_rst_n, m_in_valid, m_in_ready, m_cin, m_sub;
  logic        m_out_valid, m_out_ready, m_cout, m_ovf;
  logic [15:0] m_a, m_b, m_s;

  digit_serial_adder_sub #(.WIDTH(16), .DIGIT(4)) u_main (
    .clk(clk), .rst_n(m_rst_n), .in_valid(m_in_valid), .in_ready(m_in_ready),
    .A(m_a), .B(m_b), .Cin(m_cin), .sub(m_sub), .out_valid(m_out_valid),
    .out_ready(m_out_ready), .S(m_s), .Cout(m_cout), .ovf(m_ovf)
  );

  task automatic wait_accept(input string name, output logic ok);
    ok = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (m_in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk({name, "_accept_timeout"}, 32'd0, 32'd1);
    else @(posedge clk);
  endtask

  task automatic wait_result(input string name);
    int lat;
    lat = 0;
    for (int t = 0; t < 50; t++) begin
      @(posedge clk);
      lat++;
      #1;
      if (m_out_valid) break;
    end
    chk({name, "_latency"}, 32'(lat), 32'd4);
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                        input logic sub, input logic [15:0] es, input logic ec,
                        input logic eo, input string name);
    logic ok;
    chk({name, "_model"}, 32'(model(16, a, b, cin, sub)), 32'({eo, ec, es}));
    @(posedge clk);
    #1;
    m_a = a; m_b = b; m_cin = cin; m_sub = sub;
    m_in_valid = 1'b1;
    m_out_ready = 1'b1;
    wait_accept(name, ok);
    if (ok) begin
      #1;
      m_in_valid = 1'b0;
      m_a = 16'($urandom); m_b = 16'($urandom); m_cin = 1'($urandom); m_sub = 1'($urandom);
      wait_result(name);
      chk({name, "_S"}, 32'(m_s), 32'(es));
      chk({name, "_Cout"}, 32'(m_cout), 32'(ec));
      chk({name, "_ovf"}, 32'(m_ovf), 32'(eo));
      @(posedge clk);
      #1;
      chk({name, "_handoff"}, 32'(m_out_valid), 32'd0);
    end
  endtask

  // ---------------- randomized instances ----------------
  localparam int NOPS = 1500;
  logic r_rst_n;

  for (genvar g = 0; g < 4; g++) begin : cfg
    localparam int W    = (g == 3) ? 12 : 16;
    localparam int D    = (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 16 : 3;
    localparam int NDIG = W / D;

    logic         in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
    logic [W-1:0] a, b, s;
    logic         done = 1'b0;
    logic         prev_ov = 1'b0;
    logic [17:0]  exp_q[$];
    int           acc_q[$];

    digit_serial_adder_sub #(.WIDTH(W), .DIGIT(D)) u_dut (
      .clk(clk), .rst_n(r_rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .A(a), .B(b), .Cin(cin), .sub(sub), .out_valid(out_valid),
      .out_ready(out_ready), .S(s), .Cout(cout), .ovf(ovf)
    );

    initial begin
      out_ready = 1'b0;
      forever begin
        @(posedge clk);
        #1;
        out_ready = ($urandom_range(0, 3) != 0);
      end
    end

    initial begin
      logic ok;
      int n;
      in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      for (int i = 0; i < NOPS; i++) begin
        a = W'($urandom); b = W'($urandom);
        cin = 1'($urandom); sub = 1'($urandom);
        in_valid = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 400; t++) begin
          @(negedge clk);
          if (in_ready) begin
            ok = 1'b1;
            break;
          end
        end
        if (!ok) begin
          chk($sformatf("rand%0d_accept_timeout", g), 32'd0, 32'd1);
          break;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom);
        n = $urandom_range(0, 2);
        repeat (n) begin
          @(posedge clk);
          #1;
        end
      end
      repeat (NDIG + 40) @(posedge clk);
      chk($sformatf("rand%0d_drained", g), 32'(exp_q.size()), 32'd0);
      done = 1'b1;
    end

    always @(negedge clk) begin
      if (r_rst_n) begin
        if (in_valid && in_ready) begin
          exp_q.push_back(model(W, 16'(a), 16'(b), cin, sub));
          acc_q.push_back(cyc + 1);
        end
        if (in_ready && out_valid) chk($sformatf("rand%0d_ready_valid_overlap", g), 32'd1, 32'd0);
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            chk($sformatf("rand%0d_unexpected_out", g), 32'd1, 32'd0);
          end else begin
            chk($sformatf("rand%0d_S", g), 32'(s), 32'(exp_q[0][15:0]));
            chk($sformatf("rand%0d_Cout", g), 32'(cout), 32'(exp_q[0][16]));
            chk($sformatf("rand%0d_ovf", g), 32'(ovf), 32'(exp_q[0][17]));
            if (!prev_ov) chk($sformatf("rand%0d_latency", g), 32'(cyc - acc_q[0]), 32'(NDIG));
            if (out_ready) begin
              void'(exp_q.pop_front());
              void'(acc_q.pop_front());
            end
          end
        end
        prev_ov <= out_valid;
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    logic ok;
    m_rst_n = 1'b0; r_rst_n = 1'b0;
    m_in_valid = 1'b0; m_out_ready = 1'b0;
    m_a = '0; m_b = '0; m_cin = 1'b0; m_sub = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", 32'(m_in_ready), 32'd0);
    chk("reset_out_valid", 32'(m_out_valid), 32'd0);
    chk("reset_S", 32'(m_s), 32'd0);
    chk("reset_Cout", 32'(m_cout), 32'd0);
    chk("reset_ovf", 32'(m_ovf), 32'd0);
    m_rst_n = 1'b1; r_rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_reset_in_ready", 32'(m_in_ready), 32'd1);

    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "add_wrap");
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "add_ovf");
    run_op(16'h1234, 16'h0000, 1'b1, 1'b0, 16'h1235, 1'b0, 1'b0, "add_cin");
    run_op(16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1, "sub_ovf");
    run_op(16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_borrow");

    // Backpressure: first result held for 5 cycles while a second request waits.
    @(posedge clk);
    #1;
    m_a = 16'h00F0; m_b = 16'h0F0F; m_cin = 1'b0; m_sub = 1'b0;
    m_in_valid = 1'b1; m_out_ready = 1'b0;
    wait_accept("bp", ok);
    #1;
    m_a = 16'h1111; m_b = 16'h2222;
    wait_result("bp");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_hold_S", 32'(m_s), 32'h0FFF);
      chk("bp_hold_Cout", 32'(m_cout), 32'd0);
      chk("bp_hold_ovf", 32'(m_ovf), 32'd0);
      chk("bp_hold_out_valid", 32'(m_out_valid), 32'd1);
      chk("bp_hold_in_ready", 32'(m_in_ready), 32'd0);
    end
    m_out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_handoff_out_valid", 32'(m_out_valid), 32'd0);
    chk("bp_handoff_in_ready", 32'(m_in_ready), 32'd1);
    @(posedge clk);
    #1;
    chk("bp_second_accept", 32'(m_in_ready), 32'd0);
    m_in_valid = 1'b0;
    wait_result("bp2");
    chk("bp2_S", 32'(m_s), 32'h3333);
    @(posedge clk);

    // Reset during the second RUN cycle discards the operation.
    #1;
    m_a = 16'h8123; m_b = 16'h8456; m_cin = 1'b0; m_sub = 1'b0;
    m_in_valid = 1'b1;
    wait_accept("rst", ok);
    #1;
    m_in_valid = 1'b0;
    @(posedge clk);
    #1;
    m_rst_n = 1'b0;
    #1;
    chk("midrun_rst_out_valid", 32'(m_out_valid), 32'd0);
    chk("midrun_rst_S", 32'(m_s), 32'd0);
    chk("midrun_rst_Cout", 32'(m_cout), 32'd0);
    chk("midrun_rst_ovf", 32'(m_ovf), 32'd0);
    chk("midrun_rst_in_ready", 32'(m_in_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    m_rst_n = 1'b1;
    run_op(16'h8123, 16'h8456, 1'b0, 1'b0, 16'h0579, 1'b1, 1'b1, "after_rst");

    ok = 1'b0;
    for (int t = 0; t < 80000; t++) begin
      @(posedge clk);
      if (cfg[0].done && cfg[1].done && cfg[2].done && cfg[3].done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("random_timeout", 32'd0, 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
